// File: rtl/tpu_pkg.sv
// tpu_pkg: shared sizes and state encoding for the weight path (memArr, weightFifo, load controller)
package tpu_pkg;
  localparam int WIDTH_HEIGHT = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int ADDR_W = 8;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;
endpackage

// File: rtl/weight_load_ctrl_stagger_mask.sv
// stagger_mask: per-lane enable window, lane c active while c <= cnt < c+FIFO_DEPTH
//   cnt  in   cycle index within the drain phase (0-based)
//   mask out  one enable bit per lane
module stagger_mask #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = 6
) (
  input  logic [CNT_W-1:0]        cnt,
  output logic [WIDTH_HEIGHT-1:0] mask
);
  always_comb begin
    mask = '0;
    for (int c = 0; c < WIDTH_HEIGHT; c++)
      mask[c] = int'(cnt) >= c && int'(cnt) < c + FIFO_DEPTH;
  end
endmodule

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: sequences memArr -> weightFifo loads and staggered weightFifo drains
//   load_start/load_base  begin LOAD of FIFO_DEPTH rows from load_base (IDLE only)
//   drain_start           begin DRAIN with one-cycle-per-column skew (IDLE only)
//   mem_rd_en/mem_rd_addr memArr read controls, same row on every lane
//   fifo_en/fifo_src_mem  weightFifo shift enables and input select (1: memArr data, 0: zero)
//   busy/load_done/drain_done status; all outputs registered, zero after reset
module weight_load_ctrl #(
  parameter int WIDTH_HEIGHT = tpu_pkg::WIDTH_HEIGHT,
  parameter int FIFO_DEPTH = tpu_pkg::FIFO_DEPTH,
  parameter int ADDR_W = tpu_pkg::ADDR_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_start,
  input  logic [ADDR_W-1:0]              load_base,
  input  logic                           drain_start,
  output logic [WIDTH_HEIGHT-1:0]        mem_rd_en,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] mem_rd_addr,
  output logic [WIDTH_HEIGHT-1:0]        fifo_en,
  output logic                           fifo_src_mem,
  output logic                           busy,
  output logic                           load_done,
  output logic                           drain_done
);
  import tpu_pkg::*;
  localparam int CW = $clog2(WIDTH_HEIGHT + FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LOAD_LAST = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(WIDTH_HEIGHT + FIFO_DEPTH - 2);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [WIDTH_HEIGHT-1:0] mem_rd_en_q, mem_rd_en_d, fifo_en_q, fifo_en_d, mask;
  logic fifo_src_mem_q, fifo_src_mem_d, busy_q, busy_d;
  logic load_done_q, load_done_d, drain_done_q, drain_done_d, rd_on;
  // Outputs are derived from the next state so they line up with the cycle that state is entered.
  stagger_mask #(.WIDTH_HEIGHT(WIDTH_HEIGHT), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CW)) u_mask (
    .cnt (cnt_d),
    .mask(mask)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    base_d = base_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (load_start) begin
        state_d = LOAD;
        base_d = load_base;
      end else if (drain_start) state_d = DRAIN;
    end else if ((state_q == LOAD && cnt_q == LOAD_LAST) || (state_q == DRAIN && cnt_q == DRAIN_LAST)) begin
      state_d = IDLE;
      cnt_d = '0;
    end
    rd_on = state_d == LOAD && cnt_d < LOAD_LAST;
    mem_rd_en_d = {WIDTH_HEIGHT{rd_on}};
    addr_d = rd_on ? base_d + ADDR_W'(cnt_d) : addr_q;
    // Load pushes lag reads by one cycle to cover memArr read latency.
    fifo_en_d = state_d == LOAD ? {WIDTH_HEIGHT{cnt_d != '0}} : state_d == DRAIN ? mask : '0;
    fifo_src_mem_d = state_d == LOAD && cnt_d != '0;
    busy_d = state_d != IDLE;
    load_done_d = state_d == LOAD && cnt_d == LOAD_LAST;
    drain_done_d = state_d == DRAIN && cnt_d == DRAIN_LAST;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_q <= '0;
      addr_q <= '0;
      mem_rd_en_q <= '0;
      fifo_en_q <= '0;
      fifo_src_mem_q <= 1'b0;
      busy_q <= 1'b0;
      load_done_q <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      base_q <= base_d;
      addr_q <= addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      fifo_en_q <= fifo_en_d;
      fifo_src_mem_q <= fifo_src_mem_d;
      busy_q <= busy_d;
      load_done_q <= load_done_d;
      drain_done_q <= drain_done_d;
    end
  end
  assign mem_rd_en = mem_rd_en_q;
  assign mem_rd_addr = {WIDTH_HEIGHT{addr_q}};
  assign fifo_en = fifo_en_q;
  assign fifo_src_mem = fifo_src_mem_q;
  assign busy = busy_q;
  assign load_done = load_done_q;
  assign drain_done = drain_done_q;
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: directed bench with a phase-level model, memArr/weightFifo models and literal pins
module tb_weight_load_ctrl;
  localparam int W = 16;
  localparam int FD = 16;
  localparam int AW = 8;
  logic clk = 0, reset = 1, load_start = 0, drain_start = 0;
  logic [AW-1:0] load_base = '0;
  logic [W-1:0] mem_rd_en, fifo_en;
  logic [W*AW-1:0] mem_rd_addr;
  logic fifo_src_mem, busy, load_done, drain_done;
  int errs = 0, checks = 0;
  weight_load_ctrl dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_base(load_base),
    .drain_start(drain_start), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .fifo_en(fifo_en), .fifo_src_mem(fifo_src_mem), .busy(busy),
    .load_done(load_done), .drain_done(drain_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [W*AW-1:0] act, input logic [W*AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Phase model: mode 0 idle, 1 load, 2 drain; k is the 1-based cycle within the phase.
  int m_mode = 0, m_k = 0;
  logic [AW-1:0] m_base = '0, m_addr = '0;
  bit started = 0;
  always @(posedge clk) begin
    int md, k;
    logic [AW-1:0] b, a;
    md = m_mode; k = m_k; b = m_base; a = m_addr;
    if (reset) begin
      md = 0; k = 0; a = '0;
    end else if (md == 0) begin
      if (load_start) begin md = 1; k = 1; b = load_base; end
      else if (drain_start) begin md = 2; k = 1; end
    end else begin
      k++;
      if ((md == 1 && k > FD + 1) || (md == 2 && k > W + FD - 1)) begin md = 0; k = 0; end
    end
    if (md == 1 && k <= FD) a = b + AW'(k - 1);
    m_mode <= md; m_k <= k; m_base <= b; m_addr <= a;
    started <= 1;
  end
  always @(negedge clk) if (started) begin
    logic [W-1:0] ef;
    ef = '0;
    for (int c = 0; c < W; c++)
      ef[c] = (m_mode == 1 && m_k >= 2) || (m_mode == 2 && c <= m_k - 1 && m_k - 1 < c + FD);
    chk("rd_en", mem_rd_en, (m_mode == 1 && m_k <= FD) ? {W{1'b1}} : '0);
    chk("rd_addr", mem_rd_addr, {W{m_addr}});
    chk("fifo_en", fifo_en, ef);
    chk("src_mem", fifo_src_mem, m_mode == 1 && m_k >= 2);
    chk("busy", busy, m_mode != 0);
    chk("load_done", load_done, m_mode == 1 && m_k == FD + 1);
    chk("drain_done", drain_done, m_mode == 2 && m_k == W + FD - 1);
  end
  // memArr (1-cycle read latency) and weightFifo (shift-in at tail, pop at head) models.
  logic [AW-1:0] mem [W][256];
  logic [AW-1:0] rd_data [W];
  logic [AW-1:0] fq [W][FD];
  logic [AW-1:0] popq [W][$];
  int first_pop [W];
  initial begin
    for (int i = 0; i < W; i++) begin
      rd_data[i] = '0;
      first_pop[i] = -1;
      for (int r = 0; r < 256; r++) mem[i][r] = AW'(r + i);
      for (int j = 0; j < FD; j++) fq[i][j] = 8'hEE;
    end
  end
  always @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      if (mem_rd_en[i]) rd_data[i] <= mem[i][mem_rd_addr[i*AW +: AW]];
      if (fifo_en[i]) begin
        if (m_mode == 2) begin
          if (popq[i].size() == 0) first_pop[i] <= m_k;
          popq[i].push_back(fq[i][0]);
        end
        for (int j = 0; j < FD - 1; j++) fq[i][j] <= fq[i][j+1];
        fq[i][FD-1] <= fifo_src_mem ? rd_data[i] : '0;
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic go(input bit ld, input bit dr, input logic [AW-1:0] b);
    load_start = ld; drain_start = dr; load_base = b;
    cyc(1);
    load_start = 0; drain_start = 0;
  endtask
  initial begin
    // 1 reset, with requests pulsed while reset is held
    cyc(2);
    load_start = 1; drain_start = 1; load_base = 8'h33;
    cyc(1);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_en", fifo_en, 0);
    load_start = 0; drain_start = 0; reset = 0;
    cyc(2);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rd_en", mem_rd_en, 0);
    // 2 load rows 0x10..0x1F
    go(1, 0, 8'h10);
    chk("ld_c1_rd_en", mem_rd_en, 16'hFFFF);
    chk("ld_c1_addr", mem_rd_addr, {W{8'h10}});
    chk("ld_c1_fifo_en", fifo_en, 0);
    cyc(15);
    chk("ld_c16_addr", mem_rd_addr, {W{8'h1F}});
    cyc(1);
    chk("ld_c17_done", load_done, 1);
    chk("ld_c17_rd_en", mem_rd_en, 0);
    cyc(1);
    chk("ld_c18_busy", busy, 0);
    for (int i = 0; i < W; i++) begin
      logic [FD*AW-1:0] act, exp;
      for (int j = 0; j < FD; j++) begin
        act[j*AW +: AW] = fq[i][j];
        exp[j*AW +: AW] = AW'(8'h10 + j + i);
      end
      chk($sformatf("fifo_lane%0d", i), act, exp);
    end
    // 3 drain
    go(0, 1, 8'h00);
    chk("dr_c1_fifo_en", fifo_en, 16'h0001);
    chk("dr_c1_src", fifo_src_mem, 0);
    cyc(15);
    chk("dr_c16_fifo_en", fifo_en, 16'hFFFF);
    cyc(15);
    chk("dr_c31_fifo_en", fifo_en, 16'h8000);
    chk("dr_c31_done", drain_done, 1);
    cyc(1);
    chk("dr_c32_busy", busy, 0);
    for (int c = 0; c < W; c++) begin
      logic [FD*AW-1:0] act, exp;
      act = '0; exp = '0;
      for (int j = 0; j < FD; j++) begin
        if (j < popq[c].size()) act[j*AW +: AW] = popq[c][j];
        exp[j*AW +: AW] = AW'(8'h10 + j + c);
      end
      chk($sformatf("pop_cnt%0d", c), popq[c].size(), FD);
      chk($sformatf("pop_seq%0d", c), act, exp);
      chk($sformatf("pop_first%0d", c), first_pop[c], c + 1);
      chk($sformatf("zero_fill%0d", c), fq[c][0] | fq[c][FD-1], 0);
    end
    // 4 address wrap
    go(1, 0, 8'hF8);
    cyc(7);
    chk("wrap_c8_addr", mem_rd_addr, {W{8'hFF}});
    cyc(1);
    chk("wrap_c9_addr", mem_rd_addr, {W{8'h00}});
    cyc(7);
    chk("wrap_c16_addr", mem_rd_addr, {W{8'h07}});
    cyc(3);
    chk("wrap_hold_addr", mem_rd_addr, {W{8'h07}});
    // 5 collisions
    go(1, 1, 8'h20);
    cyc(16);
    chk("both_c17_done", load_done, 1);
    cyc(3);
    chk("both_no_drain", busy, 0);
    go(1, 0, 8'h40);
    cyc(4);
    drain_start = 1;
    cyc(1);
    drain_start = 0;
    cyc(11);
    chk("busy_ign_c17", busy, 1);
    cyc(1);
    chk("busy_ign_c18", busy, 0);
    cyc(2);
    chk("busy_ign_c20", busy, 0);
    // 6 abort during drain
    go(0, 1, 8'h00);
    cyc(7);
    reset = 1;
    cyc(1);
    chk("abort_fifo_en", fifo_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", drain_done, 0);
    reset = 0;
    cyc(1);
    go(1, 0, 8'h50);
    chk("after_abort_addr", mem_rd_addr, {W{8'h50}});
    cyc(16);
    chk("after_abort_done", load_done, 1);
    cyc(3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
